// File: rtl/cache_pkg.sv
// Shared types for the set-associative cache controllers: request ops, MESI states and the
// per-way line record held in the tag/state/age arrays.
package cache_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  // Sized for the widest supported configuration (16 ways, tags up to 32 bits); unused upper
  // bits are always written as zero.
  localparam int unsigned AgeW = $clog2(16);

  typedef struct packed {
    logic [31:0]     tag;
    mesi_t           mesi;
    logic [AgeW-1:0] age;
  } line_t;

endpackage

// File: rtl/lru_victim.sv
// Combinational tag match and victim choice over one set: lowest invalid way first, otherwise
// the way whose age is WAYS-1.
module lru_victim
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned TAG_W = 12
) (
  input  line_t [WAYS-1:0]         lines_i,
  input  logic  [TAG_W-1:0]        tag_i,
  output logic                     hit_o,
  output logic [$clog2(WAYS)-1:0]  hit_way_o,
  output logic [$clog2(WAYS)-1:0]  victim_way_o
);

  localparam int unsigned WayW = $clog2(WAYS);

  always_comb begin
    hit_o        = 1'b0;
    hit_way_o    = '0;
    victim_way_o = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (lines_i[w].mesi != MESI_I && lines_i[w].tag == 32'(tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WayW'(w);
      end
      if (lines_i[w].age == AgeW'(WAYS - 1)) begin
        victim_way_o = WayW'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins over the oldest way.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (lines_i[w].mesi == MESI_I) begin
        victim_way_o = WayW'(w);
      end
    end
  end

endmodule

// File: rtl/cache_set_ctrl.sv
// N-way set-associative cache controller: owns tag/MESI/age arrays, serves one request at a
// time, sequences writeback and fill, and keeps true-LRU ages and hit/miss/evict statistics.
module cache_set_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SETS  = 1024,
  parameter int unsigned TAG_W = 12,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  op_t                      req_op,
  input  logic [$clog2(SETS)-1:0]  req_set,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [$clog2(WAYS)-1:0]  rsp_way,
  output mesi_t                    rsp_mesi,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [$clog2(SETS)-1:0]  wb_set,
  output logic [TAG_W-1:0]         wb_tag,
  input  logic                     fill_valid,
  input  logic                     fill_shared,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [CNT_W-1:0]         evict_cnt
);

  localparam int unsigned SetW = $clog2(SETS);
  localparam int unsigned WayW = $clog2(WAYS);

  typedef enum logic [2:0] {StInit, StIdle, StLookup, StEvict, StFill, StUpdate} state_e;

  state_e            state_q, state_d;
  logic [SetW-1:0]   init_set_q, init_set_d, set_q, set_d;
  logic              clear_q, clear_d, hit_q, hit_d, shared_q, shared_d;
  op_t               op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d, wb_tag_q, wb_tag_d;
  logic [WayW-1:0]   way_q, way_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, evict_cnt_q, evict_cnt_d;

  line_t [WAYS-1:0]  mem_q [SETS];
  line_t [WAYS-1:0]  cur_lines, wr_lines;
  logic              wr_en;
  logic [SetW-1:0]   wr_set;
  mesi_t             upd_mesi;
  logic              lv_hit, init_last;
  logic [WayW-1:0]   lv_hit_way, lv_victim_way;

  assign cur_lines = mem_q[set_q];
  assign init_last = (init_set_q == SetW'(SETS - 1));

  lru_victim #(
    .WAYS (WAYS),
    .TAG_W(TAG_W)
  ) u_lru_victim (
    .lines_i     (cur_lines),
    .tag_i       (tag_q),
    .hit_o       (lv_hit),
    .hit_way_o   (lv_hit_way),
    .victim_way_o(lv_victim_way)
  );

  // Array write port: INIT clears one set per cycle, UPDATE rewrites the request's set once.
  always_comb begin
    wr_en    = 1'b0;
    wr_set   = set_q;
    wr_lines = cur_lines;
    unique case (op_q)
      OP_READ:  upd_mesi = hit_q ? cur_lines[way_q].mesi : (shared_q ? MESI_S : MESI_E);
      OP_WRITE: upd_mesi = MESI_M;
      OP_INVAL: upd_mesi = MESI_I;
      OP_CLEAR: upd_mesi = MESI_I;
    endcase
    if (state_q == StInit) begin
      wr_en  = 1'b1;
      wr_set = init_set_q;
      for (int w = 0; w < int'(WAYS); w++) begin
        wr_lines[w] = '{tag: '0, mesi: MESI_I, age: AgeW'(w)};
      end
    end else if (state_q == StUpdate && (op_q != OP_INVAL || hit_q)) begin
      wr_en                  = 1'b1;
      wr_lines[way_q].mesi   = upd_mesi;
      if (op_q != OP_INVAL) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          if (cur_lines[w].age < cur_lines[way_q].age) begin
            wr_lines[w].age = cur_lines[w].age + AgeW'(1);
          end
        end
        wr_lines[way_q].age = '0;
        wr_lines[way_q].tag = 32'(tag_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_set] <= wr_lines;
  end

  always_comb begin
    state_d     = state_q;
    init_set_d  = init_set_q;
    clear_d     = clear_q;
    op_d        = op_q;
    set_d       = set_q;
    tag_d       = tag_q;
    way_d       = way_q;
    hit_d       = hit_q;
    shared_d    = shared_q;
    wb_tag_d    = wb_tag_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    evict_cnt_d = evict_cnt_q;
    unique case (state_q)
      StInit: begin
        init_set_d = init_set_q + SetW'(1);
        if (init_last) begin
          state_d = StIdle;
          clear_d = 1'b0;
        end
      end
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          set_d   = req_set;
          tag_d   = req_tag;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (op_q == OP_CLEAR) begin
          init_set_d = '0;
          clear_d    = 1'b1;
          state_d    = StInit;
        end else if (op_q == OP_INVAL) begin
          hit_d    = lv_hit;
          way_d    = lv_hit ? lv_hit_way : '0;
          wb_tag_d = cur_lines[lv_hit_way].tag[TAG_W-1:0];
          state_d  = (lv_hit && cur_lines[lv_hit_way].mesi == MESI_M) ? StEvict : StUpdate;
        end else if (lv_hit) begin
          hit_d     = 1'b1;
          way_d     = lv_hit_way;
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
          state_d   = StUpdate;
        end else begin
          hit_d      = 1'b0;
          way_d      = lv_victim_way;
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          wb_tag_d   = cur_lines[lv_victim_way].tag[TAG_W-1:0];
          state_d    = (cur_lines[lv_victim_way].mesi == MESI_M) ? StEvict : StFill;
        end
      end
      StEvict: begin
        if (wb_ready) begin
          evict_cnt_d = evict_cnt_q + CNT_W'(1);
          state_d     = (op_q == OP_INVAL) ? StUpdate : StFill;
        end
      end
      StFill: begin
        if (fill_valid) begin
          shared_d = fill_shared;
          state_d  = StUpdate;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_set_q  <= '0;
      clear_q     <= 1'b0;
      op_q        <= OP_READ;
      set_q       <= '0;
      tag_q       <= '0;
      way_q       <= '0;
      hit_q       <= 1'b0;
      shared_q    <= 1'b0;
      wb_tag_q    <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_set_q  <= init_set_d;
      clear_q     <= clear_d;
      op_q        <= op_d;
      set_q       <= set_d;
      tag_q       <= tag_d;
      way_q       <= way_d;
      hit_q       <= hit_d;
      shared_q    <= shared_d;
      wb_tag_q    <= wb_tag_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      evict_cnt_q <= evict_cnt_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  // A CLEAR completes on the last INIT cycle of its walk.
  assign rsp_valid = (state_q == StUpdate) || (state_q == StInit && init_last && clear_q);
  assign rsp_hit   = (state_q == StUpdate) && hit_q;
  assign rsp_way   = (state_q == StUpdate) ? way_q : '0;
  assign rsp_mesi  = (state_q == StUpdate) ? upd_mesi : MESI_I;
  assign wb_valid  = (state_q == StEvict);
  assign wb_set    = set_q;
  assign wb_tag    = wb_tag_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign evict_cnt = evict_cnt_q;

endmodule
